// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU.
// Holds the instruction field widths, the opcode map that control_unit decodes,
// the fetch FSM state encoding and small helpers that split an instruction
// word into opcode and operand.
package cpu_pkg;

  localparam int INSTR_W   = 8;
  localparam int OPCODE_W  = 4;
  localparam int OPERAND_W = 4;

  // Opcode map (IR[7:4]).
  localparam logic [OPCODE_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_LDI = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_OR  = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

  // Fetch FSM state encoding.
  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_WAIT   = 2'b01,
    ST_FULL   = 2'b10,
    ST_HALTED = 2'b11
  } fetch_state_t;

  // Opcode field of an instruction word.
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1:INSTR_W-OPCODE_W];
  endfunction

  // Operand field of an instruction word.
  function automatic logic [OPERAND_W-1:0] operand_of(input logic [INSTR_W-1:0] instr);
    return instr[OPERAND_W-1:0];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter register with synchronous active-low reset, load and
// increment. Load wins over increment; increment wraps modulo 2^PC_W.
// Ports:
//   clk      - system clock
//   reset    - synchronous active-low reset, loads RESET_PC
//   load_en  - load load_val into the PC
//   load_val - new PC value (jump target)
//   inc_en   - advance PC by one
//   pc       - current PC
module program_counter #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc_en,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_r;

  // PC register: reset > load > increment > hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r <= RESET_PC;
    end else if (load_en) begin
      pc_r <= load_val;
    end else if (inc_en) begin
      pc_r <= pc_r + PC_W'(1);
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit of the 4-bit CPU.
// Owns the PC (via program_counter), a one-entry fetch buffer and the IR, and
// reads program memory with a req/valid handshake. control_unit consumes the
// buffer with ir_load_en, redirects with jump_en and stops fetching with halt.
// Ports:
//   clk, reset            - clock, synchronous active-low reset
//   mem_req, mem_addr     - program-memory read request and address
//   mem_rdata, mem_valid  - program-memory read data and its valid strobe
//   ir_load_en            - move fetch buffer into IR
//   jump_en               - redirect PC to the IR operand
//   halt                  - enter the terminal HALTED state
//   opcode, operand       - IR fields
//   pc                    - address of the next instruction to fetch
//   ir_valid              - IR holds a real fetched instruction
//   fetch_stall           - ir_load_en was seen with an empty buffer
//   halted                - sticky halt indication
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_valid,
  input  logic               ir_load_en,
  input  logic               jump_en,
  input  logic               halt,
  output logic [3:0]         opcode,
  output logic [3:0]         operand,
  output logic [PC_W-1:0]    pc,
  output logic               ir_valid,
  output logic               fetch_stall,
  output logic               halted
);

  fetch_state_t       state_r;
  logic [INSTR_W-1:0] buf_r;
  logic [INSTR_W-1:0] ir_r;
  logic               ir_valid_r;
  logic               mem_req_r;
  logic               fetch_stall_r;
  logic               halted_r;
  // Set when a jump lands while a read is still outstanding; the stale
  // response must be dropped when it finally arrives.
  logic               discard_r;

  logic               pc_load_s;
  logic               pc_inc_s;
  logic [PC_W-1:0]    pc_s;
  logic [PC_W-1:0]    jump_target_s;

  assign jump_target_s = {{(PC_W-OPERAND_W){1'b0}}, operand_of(ir_r)};

  // PC control: halt freezes the PC, jump loads it, a kept response advances it.
  always_comb begin
    pc_load_s = 1'b0;
    pc_inc_s  = 1'b0;
    if (state_r == ST_HALTED || halt) begin
      pc_load_s = 1'b0;
      pc_inc_s  = 1'b0;
    end else if (jump_en) begin
      pc_load_s = 1'b1;
    end else if (state_r == ST_WAIT && mem_valid && !discard_r) begin
      pc_inc_s = 1'b1;
    end else begin
      pc_inc_s = 1'b0;
    end
  end

  program_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load_en  (pc_load_s),
    .load_val (jump_target_s),
    .inc_en   (pc_inc_s),
    .pc       (pc_s)
  );

  // Fetch FSM with registered outputs; priority halt > jump > load > capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_FETCH;
      buf_r         <= '0;
      ir_r          <= '0;
      ir_valid_r    <= 1'b0;
      mem_req_r     <= 1'b0;
      fetch_stall_r <= 1'b0;
      halted_r      <= 1'b0;
      discard_r     <= 1'b0;
    end else if (state_r == ST_HALTED) begin
      state_r <= ST_HALTED;
    end else if (halt) begin
      state_r       <= ST_HALTED;
      halted_r      <= 1'b1;
      mem_req_r     <= 1'b0;
      fetch_stall_r <= 1'b0;
      discard_r     <= 1'b0;
    end else if (jump_en) begin
      // Jump flushes the buffer and invalidates IR; a concurrent ir_load_en is ignored.
      buf_r         <= '0;
      ir_valid_r    <= 1'b0;
      fetch_stall_r <= 1'b0;
      mem_req_r     <= 1'b1;
      if (state_r == ST_WAIT && !mem_valid) begin
        discard_r <= 1'b1;
        state_r   <= ST_WAIT;
      end else begin
        discard_r <= 1'b0;
        state_r   <= ST_FETCH;
      end
    end else begin
      // The buffer is only occupied in FULL.
      fetch_stall_r <= ir_load_en && (state_r != ST_FULL);
      case (state_r)
        ST_FETCH: begin
          state_r   <= ST_WAIT;
          mem_req_r <= 1'b1;
        end
        ST_WAIT: begin
          if (mem_valid && discard_r) begin
            discard_r <= 1'b0;
            state_r   <= ST_FETCH;
            mem_req_r <= 1'b1;
          end else if (mem_valid) begin
            buf_r     <= mem_rdata;
            state_r   <= ST_FULL;
            mem_req_r <= 1'b0;
          end else begin
            mem_req_r <= 1'b1;
          end
        end
        ST_FULL: begin
          if (ir_load_en) begin
            ir_r       <= buf_r;
            ir_valid_r <= 1'b1;
            state_r    <= ST_FETCH;
            mem_req_r  <= 1'b1;
          end else begin
            mem_req_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_FETCH;
          mem_req_r <= 1'b1;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_r;
  assign mem_addr    = pc_s;
  assign pc          = pc_s;
  assign opcode      = opcode_of(ir_r);
  assign operand     = operand_of(ir_r);
  assign ir_valid    = ir_valid_r;
  assign fetch_stall = fetch_stall_r;
  assign halted      = halted_r;

endmodule
